// File: rtl/seq_div12_pkg.sv
// Shared constants and types for the sequential restoring divider.
package seq_div12_pkg;

    localparam int unsigned DIV_WIDTH = 12;

    // Quotient reported when the captured divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_div12_sub13.sv
// Combinational ripple subtractor: diff = a - b, formed as a + ~b + 1.
// borrow is high when b > a (no carry out of the top bit).
module sub13 #(
    parameter int unsigned N = 13
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry;

    // Ripple the carry from bit 0 upward through full-adder cells.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            diff[i]      = a[i] ^ ~b[i] ^ carry[i];
            carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
        end
        borrow = ~carry[N];
    end

endmodule

// File: rtl/seq_div12.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero skips the iterations and reports all-ones / dividend.
module seq_div12
    import seq_div12_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   work_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   prem_q;      // partial remainder
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic [WIDTH:0]     trial_a_d;
    logic [WIDTH:0]     trial_b_d;
    logic [WIDTH:0]     trial_diff_d;
    logic               trial_borrow_d;
    logic               qbit_d;
    logic [WIDTH-1:0]   prem_d;
    logic [WIDTH-1:0]   work_d;

    sub13 #(
        .N(WIDTH + 1)
    ) u_sub13 (
        .a      (trial_a_d),
        .b      (trial_b_d),
        .diff   (trial_diff_d),
        .borrow (trial_borrow_d)
    );

    // One restoring step: shift in the next dividend bit and try subtracting.
    // Sign bit and borrow agree over the reachable operand range.
    always_comb begin
        trial_a_d = {prem_q, work_q[WIDTH-1]};
        trial_b_d = {1'b0, divisor_q};
        qbit_d    = ~(trial_diff_d[WIDTH] | trial_borrow_d);
        prem_d    = qbit_d ? trial_diff_d[WIDTH-1:0] : trial_a_d[WIDTH-1:0];
        work_d    = {work_q[WIDTH-2:0], qbit_d};
    end

    // Control FSM, iteration counter, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            divisor_q   <= '0;
            work_q      <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        divisor_q <= divisor;
                        work_q    <= dividend;
                        prem_q    <= '0;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        busy_q    <= 1'b1;
                        if (divisor == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= WIDTH'(DBZ_QUOTIENT);
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    prem_q <= prem_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        quotient_q  <= work_d;
                        remainder_q <= prem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div12.sv
// Self-checking bench for seq_div12: directed cases plus randomized operands
// checked against integer division.
module tb_seq_div12;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] dividend;
    logic [11:0] divisor;
    logic        busy;
    logic        done;
    logic [11:0] quotient;
    logic [11:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    seq_div12 #(.WIDTH(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic void ref_div(input logic [11:0] a, input logic [11:0] b,
                                    output logic [11:0] q, output logic [11:0] r,
                                    output logic z);
        if (b == 12'd0) begin
            q = 12'hFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issue one division from IDLE and check latency, busy length, held results.
    task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b);
        logic [11:0] eq, er, hq, hr;
        logic        ez, hz, stable;
        int          lat, bcnt;
        ref_div(a, b, eq, er, ez);
        hq = quotient;
        hr = remainder;
        hz = div_by_zero;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 12'($urandom);
        divisor  = 12'($urandom);
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (quotient !== hq || remainder !== hr || div_by_zero !== hz) stable = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy === 1'b1) bcnt++;
        check({tag, "_latency"}, lat, (b == 12'd0) ? 0 : 12);
        check({tag, "_busy_cycles"}, bcnt, (b == 12'd0) ? 1 : 13);
        check({tag, "_held_stable"}, 32'(stable), 1);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
        check({tag, "_result_kept"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int          dcount;
        int          bsum;
        logic [11:0] ra, rb;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        #1;
        check("reset_outputs", {quotient, remainder, 5'd0, busy, done, div_by_zero}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic and boundary divisions
        run_op("div_100_7", 12'd100, 12'd7);
        check("div_100_7_value", {quotient, remainder}, {12'd14, 12'd2});
        run_op("div_4095_1", 12'd4095, 12'd1);
        check("div_4095_1_value", {quotient, remainder}, {12'd4095, 12'd0});
        run_op("div_5_9", 12'd5, 12'd9);
        check("div_5_9_value", {quotient, remainder}, {12'd0, 12'd5});
        run_op("div_4095_4095", 12'd4095, 12'd4095);
        check("div_4095_4095_value", {quotient, remainder}, {12'd1, 12'd0});
        run_op("div_37_0", 12'd37, 12'd0);
        check("div_37_0_value", {quotient, remainder, 7'd0, div_by_zero}, {12'hFFF, 12'd37, 8'd1});

        // Busy protection: start pulses during RUN and during DONE are ignored
        @(negedge clk);
        dividend = 12'd200;
        divisor  = 12'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        dcount = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start    = (c == 5 || c == 13);
            dividend = 12'd9;
            divisor  = 12'd2;
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        start = 1'b0;
        check("busyprot_done_count", dcount, 1);
        check("busyprot_value", {quotient, remainder}, {12'd66, 12'd2});
        check("busyprot_idle_after", 32'(busy), 0);
        run_op("div_9_2", 12'd9, 12'd2);
        check("div_9_2_value", {quotient, remainder}, {12'd4, 12'd1});

        // Reset in the middle of RUN
        @(negedge clk);
        dividend = 12'd1000;
        divisor  = 12'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {quotient, remainder, 5'd0, busy, done, div_by_zero}, 0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        bsum   = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
            if (busy === 1'b1) bsum++;
        end
        check("midrun_no_done", dcount, 0);
        check("midrun_no_busy", bsum, 0);
        run_op("div_1000_10", 12'd1000, 12'd10);
        check("div_1000_10_value", {quotient, remainder}, {12'd100, 12'd0});

        // Randomized operands, divisor zero and small divisors included
        for (int n = 0; n < 500; n++) begin
            ra = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) rb = 12'd0;
            else if ($urandom_range(0, 3) == 0) rb = 12'($urandom_range(1, 15));
            else rb = 12'($urandom_range(1, 4095));
            run_op("rand", ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so the bench always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
